decoder_2_4_hold: RTL and testbench
===================================

Name: decoder_2_4_hold

Overview:
- Registered index-to-one-hot decoder. Consumes the {V,Y} code produced by the team's 4:2 priority encoder and drives exactly one of OUT_W lines high for a programmable number of cycles.
- Sits at the consumer end of an encoder link, for example driving grant, select or strobe lines.
- Accepts a code through a valid/ready handshake and holds the decoded line for HOLD cycles.
- Flags any index that has no corresponding output line.

Parameters:
- IDX_W, 2, width of the encoded index input.
- OUT_W, 4, number of one-hot output lines. Must satisfy 1 <= OUT_W <= 2**IDX_W.
- HOLD, 3, number of cycles each decoded line stays high. Range 1..255; the counter is 8 bits.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_v  in  1  code valid (the encoder's V).
- in_y  in  IDX_W  encoded index (the encoder's Y).
- in_ready  out  1  decoder can accept a code this cycle. Combinational from state.
- out  out  OUT_W  registered one-hot (or all-zero) decoded lines.
- busy  out  1  registered; high while in the HOLD state.
- err  out  1  registered; one-cycle pulse marking an out-of-range index.

Behaviour:
- Reset values (while rst_n=0, applied asynchronously): state=IDLE, cnt=0, out=0, busy=0, err=0. Asserting reset mid-hold clears out on the reset edge, without waiting for clk.
- Accept condition: in_v && in_ready, sampled on the rising edge of clk. in_y is ignored when not accepted.
- States: IDLE, HOLD, and GAP (GAP exists only with the optional feature).
- IDLE:
  - out=0, busy=0.
  - On accept with in_y < OUT_W: next cycle out = 1<<in_y, busy=1, cnt=HOLD-1, state=HOLD. Latency from accept edge to out valid is 1 cycle.
  - On accept with in_y >= OUT_W: next cycle err=1, out stays 0, state stays IDLE.
- HOLD:
  - out holds its value and cnt decrements by 1 each cycle.
  - Last HOLD cycle is cnt==0, so out is high for exactly HOLD cycles.
  - At cnt==0 with no accept: next state is IDLE (macro off) or GAP (macro on), and out goes to 0.
- in_ready:
  - Macro off: in_ready = (state==IDLE) || (state==HOLD && cnt==0).
  - Macro on: in_ready = (state==IDLE) || (state==GAP).
- Back-to-back (macro off): an accept on the last HOLD cycle reloads directly. out switches to the new one-hot on the next edge with no zero cycle, cnt=HOLD-1, state stays HOLD. A same-index reload keeps the line high continuously for 2*HOLD cycles.
- Out-of-range accept on the last HOLD cycle: err=1 next cycle, out=0, state=IDLE.
- HOLD=1: each accepted code yields a single-cycle pulse. Macro off, consecutive accepts every cycle are legal and in_ready stays high.
- err: high for exactly one cycle per out-of-range accept and never asserts together with a nonzero out change from that same code. If OUT_W == 2**IDX_W, err is constant 0.
- Invariant: out is always one-hot or zero; never two bits set.

Optional Feature:
- Macro: DECODER_2_4_HOLD_GAP_EN.
- Defined (break-before-make):
  - The last HOLD cycle transitions to GAP, and in_ready is low in HOLD.
  - GAP lasts 1 cycle with out=0 and busy=0, and in_ready=1. An accept in GAP behaves as in IDLE; otherwise GAP goes to IDLE.
  - Guarantees at least one all-zero cycle between any two decoded pulses. Minimum accept spacing is HOLD+1 cycles.
- Undefined: the GAP state is not compiled. Back-to-back reload behaves as described in Behaviour.

Test Plan:
1. Reset then basic decode: rst_n low for 2 cycles, release, in_v=1 in_y=2 for one cycle -> out=4'b0000 on the accept edge, out=4'b0100 for exactly 3 cycles, busy=1 during those cycles, then out=0 and in_ready=1.
2. Sweep all indices: in_y=0..3, each accepted while in_ready=1 -> out=0001, 0010, 0100, 1000, each held 3 cycles; never more than one bit set.
3. Back-to-back:
   - Macro off: in_y=1 then in_y=3 held valid -> 0010 for 3 cycles, then immediately 1000 for 3 cycles with no zero cycle.
   - Macro on: same stimulus -> 0010 x3, 0000 x1, then 1000 x3.
4. Out-of-range: rebuild with OUT_W=3, accept in_y=3 -> err=1 for one cycle, out stays 000, state stays IDLE; a following in_y=0 accept produces 001.
5. Reset mid-operation: accept in_y=1, drop rst_n asynchronously one cycle into HOLD (between clk edges) -> out=0 and busy=0 immediately. After release, in_ready=1 and the next accept of in_y=2 gives 0100 for 3 cycles.
6. HOLD=1 stream (macro off): in_v=1 for 4 consecutive cycles with in_y=0,1,2,3 -> out=0001, 0010, 0100, 1000 on consecutive cycles; in_ready stays 1 throughout.

Source files
------------

// File: rtl/decoder_2_4_hold.sv
// decoder_2_4_hold: registered index-to-one-hot decoder, each line held HOLD cycles.
// Define DECODER_2_4_HOLD_GAP_EN to force an all-zero gap cycle between pulses.
module decoder_2_4_hold #(
  parameter int IDX_W = 2,
  parameter int OUT_W = 4,
  parameter int HOLD  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_v,
  input  logic [IDX_W-1:0] in_y,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1
`ifdef DECODER_2_4_HOLD_GAP_EN
    ,
    S_GAP  = 2'd2
`endif
  } state_t;

  localparam logic [7:0] CNT_LD = 8'(HOLD - 1);
  localparam logic [IDX_W:0] OUT_LIM = (IDX_W + 1)'(OUT_W);

  state_t           state;
  logic [7:0]       cnt;
  logic             last;
  logic             accept;
  logic             in_range;
  logic [OUT_W-1:0] dec;

  assign last = (state == S_HOLD) && (cnt == 8'd0);

`ifdef DECODER_2_4_HOLD_GAP_EN
  assign in_ready = (state == S_IDLE) || (state == S_GAP);
`else
  assign in_ready = (state == S_IDLE) || last;
`endif

  assign accept   = in_v && in_ready;
  assign in_range = {1'b0, in_y} < OUT_LIM;

  always_comb begin
    dec = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (in_y == IDX_W'(i)) dec[i] = 1'b1;
    end
  end

  // accept is only possible in IDLE, GAP or the last HOLD cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
      out   <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        if (in_range) begin
          state <= S_HOLD;
          cnt   <= CNT_LD;
          out   <= dec;
          busy  <= 1'b1;
        end else begin
          state <= S_IDLE;
          cnt   <= 8'd0;
          out   <= '0;
          busy  <= 1'b0;
          err   <= 1'b1;
        end
      end else if (state == S_HOLD && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end else if (last) begin
`ifdef DECODER_2_4_HOLD_GAP_EN
        state <= S_GAP;
`else
        state <= S_IDLE;
`endif
        out   <= '0;
        busy  <= 1'b0;
      end else begin
        state <= S_IDLE;
        cnt   <= 8'd0;
        out   <= '0;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decoder_2_4_hold.sv
// tb_decoder_2_4_hold: three instances (default, OUT_W=3, HOLD=1)
// checked cycle by cycle against a pulse-length reference model.
module tb_decoder_2_4_hold;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v [N];
  logic [1:0] y [N];

  logic       rdy_a, busy_a, err_a;
  logic [3:0] out_a;
  logic       rdy_b, busy_b, err_b;
  logic [2:0] out_b;
  logic       rdy_c, busy_c, err_c;
  logic [3:0] out_c;

  int tests = 0;
  int fails = 0;

  int m_left [N];
  int m_idx  [N];
  bit m_err  [N];

  always #5 clk = ~clk;

  decoder_2_4_hold #(.IDX_W(2), .OUT_W(4), .HOLD(3)) u_a (
    .clk(clk), .rst_n(rst_n), .in_v(v[0]), .in_y(y[0]),
    .in_ready(rdy_a), .out(out_a), .busy(busy_a), .err(err_a)
  );

  decoder_2_4_hold #(.IDX_W(2), .OUT_W(3), .HOLD(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_v(v[1]), .in_y(y[1]),
    .in_ready(rdy_b), .out(out_b), .busy(busy_b), .err(err_b)
  );

  decoder_2_4_hold #(.IDX_W(2), .OUT_W(4), .HOLD(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_v(v[2]), .in_y(y[2]),
    .in_ready(rdy_c), .out(out_c), .busy(busy_c), .err(err_c)
  );

  function automatic int ow(int k);
    return (k == 1) ? 3 : 4;
  endfunction

  function automatic int hd(int k);
    return (k == 2) ? 1 : 3;
  endfunction

  // ready whenever no further pulse cycles are owed (or only the last one)
  function automatic bit m_ready(int k);
`ifdef DECODER_2_4_HOLD_GAP_EN
    return m_left[k] == 0;
`else
    return m_left[k] <= 1;
`endif
  endfunction

  // {in_ready, busy, err, out[3:0]}
  function automatic logic [6:0] m_vec(int k);
    logic [3:0] o;
    o = (m_left[k] > 0) ? 4'(1 << m_idx[k]) : 4'b0;
    return {m_ready(k), m_left[k] > 0, m_err[k], o};
  endfunction

  function automatic logic [6:0] d_vec(int k);
    case (k)
      0:       return {rdy_a, busy_a, err_a, out_a};
      1:       return {rdy_b, busy_b, err_b, 1'b0, out_b};
      default: return {rdy_c, busy_c, err_c, out_c};
    endcase
  endfunction

  task automatic m_reset();
    for (int k = 0; k < N; k++) begin
      m_left[k] = 0;
      m_idx[k]  = 0;
      m_err[k]  = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < N; k++) begin
      v[k] = 1'b0;
      y[k] = 2'd0;
    end
  endtask

  task automatic tick();
    bit acc [N];
    for (int k = 0; k < N; k++) acc[k] = v[k] && m_ready(k);
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      m_err[k] = acc[k] && (int'(y[k]) >= ow(k));
      if (acc[k] && int'(y[k]) < ow(k)) begin
        m_left[k] = hd(k);
        m_idx[k]  = int'(y[k]);
      end else if (m_left[k] > 0) begin
        m_left[k]--;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      tests++;
      if (d_vec(k) !== 7'b100_0000) begin
        fails++;
        $display("FAIL reset k=%0d got=%b exp=%b", k, d_vec(k), 7'b100_0000);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    v[0] = 1'b1;
    y[0] = 2'd2;
    tick();
    v[0] = 1'b0;
    tests++;
    if (out_a !== 4'b0100) begin
      fails++;
      $display("FAIL decode_first got=%b exp=%b", out_a, 4'b0100);
    end
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      tests++;
      if (d_vec(0) !== m_vec(0)) begin
        fails++;
        $display("FAIL decode c=%0d got=%b exp=%b", c, d_vec(0), m_vec(0));
      end
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 4; i++) begin
      v[0] = 1'b1;
      y[0] = 2'(i);
      tick();
      v[0] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (c > 0) tick();
        tests++;
        if (d_vec(0) !== m_vec(0) || $countones(out_a) > 1) begin
          fails++;
          $display("FAIL sweep i=%0d c=%0d got=%b exp=%b",
                   i, c, d_vec(0), m_vec(0));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit will;
    v[0] = 1'b1;
    y[0] = 2'd1;
    tick();
    y[0] = 2'd3;
    for (int c = 0; c < 9; c++) begin
      will = v[0] && m_ready(0);
      tick();
      tests++;
      if (d_vec(0) !== m_vec(0)) begin
        fails++;
        $display("FAIL b2b c=%0d got=%b exp=%b", c, d_vec(0), m_vec(0));
      end
      if (will) v[0] = 1'b0;
    end
  endtask

  task automatic test_out_of_range();
    v[1] = 1'b1;
    y[1] = 2'd3;
    tick();
    v[1] = 1'b0;
    tests++;
    if (err_b !== 1'b1 || out_b !== 3'b000 || rdy_b !== 1'b1) begin
      fails++;
      $display("FAIL oor_err got=%b exp=%b", d_vec(1), 7'b101_0000);
    end
    tick();
    tests++;
    if (d_vec(1) !== m_vec(1)) begin
      fails++;
      $display("FAIL oor_clear got=%b exp=%b", d_vec(1), m_vec(1));
    end
    v[1] = 1'b1;
    y[1] = 2'd0;
    tick();
    v[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      tests++;
      if (d_vec(1) !== m_vec(1)) begin
        fails++;
        $display("FAIL oor_next c=%0d got=%b exp=%b", c, d_vec(1), m_vec(1));
      end
    end
  endtask

  task automatic test_reset_mid();
    v[0] = 1'b1;
    y[0] = 2'd1;
    tick();
    v[0] = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    tests++;
    if (out_a !== 4'b0000 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid out=%b busy=%b exp out=0000 busy=0",
               out_a, busy_a);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tests++;
    if (d_vec(0) !== m_vec(0)) begin
      fails++;
      $display("FAIL reset_rel got=%b exp=%b", d_vec(0), m_vec(0));
    end
    v[0] = 1'b1;
    y[0] = 2'd2;
    tick();
    v[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      tests++;
      if (d_vec(0) !== m_vec(0)) begin
        fails++;
        $display("FAIL reset_after c=%0d got=%b exp=%b",
                 c, d_vec(0), m_vec(0));
      end
    end
  endtask

  task automatic test_hold1_stream();
    for (int i = 0; i < 6; i++) begin
      v[2] = (i < 4);
      y[2] = 2'(i);
      tick();
      tests++;
      if (d_vec(2) !== m_vec(2)) begin
        fails++;
        $display("FAIL hold1 i=%0d got=%b exp=%b", i, d_vec(2), m_vec(2));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        v[k] = ($urandom_range(0, 2) != 0);
        y[k] = 2'($urandom_range(0, 3));
      end
      tick();
      for (int k = 0; k < N; k++) begin
        tests++;
        if (d_vec(k) !== m_vec(k)) begin
          fails++;
          $display("FAIL random c=%0d k=%0d got=%b exp=%b",
                   c, k, d_vec(k), m_vec(k));
        end
      end
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  initial begin
    idle_inputs();
    m_reset();
    test_reset();
    test_decode();
    test_sweep();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_hold1_stream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
